// File: rtl/rst_seq.sv
// Reset sequencer: merges board, PLL-lock, button and software reset requests,
// holds everything in reset for a minimum time, then releases domains one by one.
module rst_seq #(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_DELAY     = 8,
  parameter int USE_LOCK        = 1
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   btn_n_i,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   rst_done_o,
  output logic [2:0]             rst_cause_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGE_DELAY + 1);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam bit UseLock = (USE_LOCK != 0);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;

  logic [SYNC_STAGES-1:0] rstSync_q, btnSync_q, lockSync_q;
  logic                   runEn, rawPressed, lockLoss, req;

  state_e                 state_q, state_d;
  logic                   btnPressed_q, btnPressed_d;
  logic [DW-1:0]          dbCnt_q, dbCnt_d;
  logic [HW-1:0]          holdCnt_q, holdCnt_d;
  logic [SW-1:0]          stageCnt_q, stageCnt_d;
  logic [IW-1:0]          stageIdx_q, stageIdx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [2:0]             cause_q, cause_d;

  // Synchronisers run from arstn_i alone so lock/button are already settled by cycle 0
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rstSync_q  <= '0;
      btnSync_q  <= '1;
      lockSync_q <= '0;
    end else begin
      rstSync_q  <= {rstSync_q[SYNC_STAGES-2:0], 1'b1};
      btnSync_q  <= {btnSync_q[SYNC_STAGES-2:0], btn_n_i};
      lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign runEn      = rstSync_q[SYNC_STAGES-1];
  assign rawPressed = ~btnSync_q[SYNC_STAGES-1];
  assign lockLoss   = UseLock & ~lockSync_q[SYNC_STAGES-1];
  assign req        = btnPressed_q | lockLoss | sw_rst_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= HOLD;
      btnPressed_q <= 1'b0;
      dbCnt_q      <= '0;
      holdCnt_q    <= '0;
      stageCnt_q   <= '0;
      stageIdx_q   <= '0;
      rst_q        <= '1;
      done_q       <= 1'b0;
      cause_q      <= 3'b000;
    end else if (!runEn) begin
      state_q      <= HOLD;
      btnPressed_q <= 1'b0;
      dbCnt_q      <= '0;
      holdCnt_q    <= '0;
      stageCnt_q   <= '0;
      stageIdx_q   <= '0;
      rst_q        <= '1;
      done_q       <= 1'b0;
      cause_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      btnPressed_q <= btnPressed_d;
      dbCnt_q      <= dbCnt_d;
      holdCnt_q    <= holdCnt_d;
      stageCnt_q   <= stageCnt_d;
      stageIdx_q   <= stageIdx_d;
      rst_q        <= rst_d;
      done_q       <= done_d;
      cause_q      <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (holdCnt_q == HW'(HOLD_CYCLES) && !req)
                 state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
      RELEASE: if (req)
                 state_d = HOLD;
               else if (stageCnt_q == SW'(STAGE_DELAY - 1) && stageIdx_q == IW'(NUM_DOMAINS - 1))
                 state_d = RUN;
      RUN:     if (req) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    btnPressed_d = btnPressed_q;
    dbCnt_d      = '0;
    if (rawPressed != btnPressed_q) begin
      if (dbCnt_q == DW'(DEBOUNCE_CYCLES - 1))
        btnPressed_d = rawPressed;
      else
        dbCnt_d = dbCnt_q + DW'(1);
    end

    holdCnt_d  = holdCnt_q;
    stageCnt_d = stageCnt_q;
    stageIdx_d = stageIdx_q;
    rst_d      = rst_q;
    done_d     = done_q;
    cause_d    = cause_q;

    case (state_q)
      HOLD: begin
        rst_d      = '1;
        done_d     = 1'b0;
        stageCnt_d = '0;
        if (req)
          holdCnt_d = '0;
        else if (holdCnt_q != HW'(HOLD_CYCLES))
          holdCnt_d = holdCnt_q + HW'(1);
        if (holdCnt_q == HW'(HOLD_CYCLES) && !req) begin
          rst_d[0]   = 1'b0;
          holdCnt_d  = '0;
          stageIdx_d = IW'(1);
          done_d     = (NUM_DOMAINS == 1);
        end
      end
      RELEASE, RUN: begin
        if (req) begin
          rst_d      = '1;
          done_d     = 1'b0;
          holdCnt_d  = '0;
          stageCnt_d = '0;
          stageIdx_d = '0;
          cause_d    = {sw_rst_i, lockLoss, btnPressed_q};
        end else if (state_q == RELEASE) begin
          if (stageCnt_q == SW'(STAGE_DELAY - 1)) begin
            for (int k = 0; k < NUM_DOMAINS; k++)
              if (IW'(k) == stageIdx_q) rst_d[k] = 1'b0;
            stageCnt_d = '0;
            stageIdx_d = stageIdx_q + IW'(1);
            if (stageIdx_q == IW'(NUM_DOMAINS - 1)) done_d = 1'b1;
          end else begin
            stageCnt_d = stageCnt_q + SW'(1);
          end
        end
      end
      default: rst_d = '1;
    endcase
  end

  assign rst_o       = rst_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-on staging, bounce rejection, re-triggers,
// late lock, a lock-ignoring build and asynchronous board reset.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       arstn_i, btn_n_i, pll_locked_i, sw_rst_i;
  logic [2:0] rst_o, rst_cause_o;
  logic       rst_done_o;

  logic       nlBtn, nlSw;
  logic [2:0] nlRst, nlCause;
  logic       nlDone;

  int checksTotal  = 0;
  int checksPassed = 0;

  always #5 clk_i = ~clk_i;

  rst_seq #(
    .NUM_DOMAINS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(16), .STAGE_DELAY(8), .USE_LOCK(1)
  ) u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .btn_n_i(btn_n_i),
    .pll_locked_i(pll_locked_i), .sw_rst_i(sw_rst_i),
    .rst_o(rst_o), .rst_done_o(rst_done_o), .rst_cause_o(rst_cause_o)
  );

  rst_seq #(
    .NUM_DOMAINS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(16), .STAGE_DELAY(8), .USE_LOCK(0)
  ) u_dutNoLock (
    .clk_i(clk_i), .arstn_i(arstn_i), .btn_n_i(nlBtn),
    .pll_locked_i(pll_locked_i), .sw_rst_i(nlSw),
    .rst_o(nlRst), .rst_done_o(nlDone), .rst_cause_o(nlCause)
  );

  // Single point of comparison: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected)
      checksPassed++;
    else
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic checkMain(input string tag, input logic [2:0] expRst, input logic expDone, input logic [2:0] expCause);
    checkOutput({tag, " rst"},   {29'd0, rst_o},       {29'd0, expRst});
    checkOutput({tag, " done"},  {31'd0, rst_done_o},  {31'd0, expDone});
    checkOutput({tag, " cause"}, {29'd0, rst_cause_o}, {29'd0, expCause});
  endtask

  task automatic checkNoLock(input string tag, input logic [2:0] expRst, input logic expDone);
    checkOutput({tag, " nl rst"},   {29'd0, nlRst},   {29'd0, expRst});
    checkOutput({tag, " nl done"},  {31'd0, nlDone},  {31'd0, expDone});
    checkOutput({tag, " nl cause"}, {29'd0, nlCause}, 32'd0);
  endtask

  // Inputs change on the falling edge, well away from the active edge
  task automatic applyStimulus(input logic arstn, input logic btnN, input logic locked, input logic sw);
    arstn_i      = arstn;
    btn_n_i      = btnN;
    pll_locked_i = locked;
    sw_rst_i     = sw;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    nlBtn = 1'b1;
    nlSw  = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(5);
    checkMain("in reset", 3'b111, 1'b0, 3'b000);

    // Power-on: two sync edges, then cycle 0 begins
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkMain("cycle 0", 3'b111, 1'b0, 3'b000);
    tick(16);
    checkMain("cycle 16", 3'b111, 1'b0, 3'b000);
    tick(1);
    checkMain("cycle 17", 3'b110, 1'b0, 3'b000);
    tick(7);
    checkMain("cycle 24", 3'b110, 1'b0, 3'b000);
    tick(1);
    checkMain("cycle 25", 3'b100, 1'b0, 3'b000);
    tick(7);
    checkMain("cycle 32", 3'b100, 1'b0, 3'b000);
    tick(1);
    checkMain("cycle 33", 3'b000, 1'b1, 3'b000);
    checkNoLock("power-on", 3'b000, 1'b1);

    // Short bounce is rejected
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick(10);
    checkMain("bounce 3", 3'b000, 1'b1, 3'b000);

    // Long press re-triggers; release debounce extends HOLD
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkMain("btn retrig", 3'b111, 1'b0, 3'b001);
    tick(21);
    checkMain("btn hold end", 3'b111, 1'b0, 3'b001);
    tick(1);
    checkMain("btn rel0", 3'b110, 1'b0, 3'b001);

    // Software pulse during RELEASE
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkMain("sw retrig", 3'b111, 1'b0, 3'b100);
    tick(16);
    checkMain("sw hold end", 3'b111, 1'b0, 3'b100);
    tick(1);
    checkMain("sw rel0", 3'b110, 1'b0, 3'b100);
    tick(7);
    checkMain("sw pre rel1", 3'b110, 1'b0, 3'b100);
    tick(1);
    checkMain("sw rel1", 3'b100, 1'b0, 3'b100);
    tick(7);
    checkMain("sw pre run", 3'b100, 1'b0, 3'b100);
    tick(1);
    checkMain("sw run", 3'b000, 1'b1, 3'b100);

    // Lock drop reaches the FSM two edges later, together with sw
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkMain("lock syncing", 3'b000, 1'b1, 3'b100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkMain("lock+sw", 3'b111, 1'b0, 3'b110);
    checkNoLock("lock drop", 3'b000, 1'b1);

    // Late lock: HOLD persists, release 16 cycles after lock is seen
    tick(40);
    checkMain("no lock", 3'b111, 1'b0, 3'b110);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick(18);
    checkMain("lock hold end", 3'b111, 1'b0, 3'b110);
    tick(1);
    checkMain("lock rel0", 3'b110, 1'b0, 3'b110);
    checkNoLock("lock back", 3'b000, 1'b1);

    // Board reset mid-RELEASE acts without a clock edge
    tick(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkMain("async reset", 3'b111, 1'b0, 3'b000);
    checkNoLock("async reset", 3'b111, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
